// File: rtl/bsg_manycore_store_fence_ctrl.sv
// bsg_manycore_store_fence_ctrl: remote-store credit throttle and store fence sequencer.
// Optional fence watchdog enabled by defining BSG_FENCE_TIMEOUT_EN.
module bsg_manycore_store_fence_ctrl #(
    parameter int max_out_p = 16
`ifdef BSG_FENCE_TIMEOUT_EN
  , parameter int timeout_p = 1024
`endif
  , localparam int count_width_lp = $clog2(max_out_p + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      proc_v_i,
    input  logic                      proc_is_store_i,
    output logic                      proc_ready_o,
    output logic                      net_v_o,
    input  logic                      net_ready_i,
    input  logic                      ret_v_i,
    input  logic                      ret_ready_i,
    input  logic                      fence_req_i,
    output logic                      fence_done_o,
    output logic                      fence_busy_o,
    output logic [count_width_lp-1:0] out_count_o,
    output logic                      error_o
);
    typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_e;
    state_e state, state_n;
    logic [count_width_lp-1:0] count;
    logic block, inc, dec, timeout;
    assign block = (state != IDLE) | (proc_is_store_i & (count == count_width_lp'(max_out_p)));
    assign net_v_o = reset_i & proc_v_i & ~block;
    assign proc_ready_o = reset_i & net_ready_i & ~block;
    assign inc = net_v_o & net_ready_i & proc_is_store_i;
    assign dec = ret_v_i & ret_ready_i;
    assign fence_done_o = state == DONE;
    assign fence_busy_o = state != IDLE;
    assign out_count_o = count;
`ifdef BSG_FENCE_TIMEOUT_EN
    localparam int timer_width_lp = $clog2(timeout_p + 1);
    logic [timer_width_lp-1:0] timer;
    // Held at zero outside DRAIN so it starts from zero on every DRAIN entry.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) timer <= '0;
        else timer <= (state == DRAIN) ? timer + 1'b1 : '0;
    end
    assign timeout = (state == DRAIN) && (count != '0) && (timer == timer_width_lp'(timeout_p));
`else
    assign timeout = 1'b0;
`endif
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = IDLE;
        if (state == IDLE) state_n = fence_req_i ? DRAIN : IDLE;
        else if (state == DRAIN) state_n = ((count == '0) || timeout) ? DONE : DRAIN;
    end
    // A return with nothing outstanding is an underflow; the count saturates at zero.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            count <= '0;
            error_o <= 1'b0;
        end else begin
            if (inc & ~dec) count <= count + 1'b1;
            else if (dec & ~inc & (count != '0)) count <= count - 1'b1;
            if ((dec & ~inc & (count == '0)) | timeout) error_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_bsg_manycore_store_fence_ctrl.sv
// tb_bsg_manycore_store_fence_ctrl: directed checks of throttling, counting and fencing.
module tb_bsg_manycore_store_fence_ctrl;
    logic clk = 1'b0;
    logic reset_i = 1'b1;
    logic proc_v_i = 1'b0, proc_is_store_i = 1'b0, net_ready_i = 1'b0;
    logic ret_v_i = 1'b0, ret_ready_i = 1'b0, fence_req_i = 1'b0;
    logic rdy16, v16, done16, busy16, err16;
    logic rdy4, v4, done4, busy4, err4;
    logic [4:0] cnt16;
    logic [2:0] cnt4;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bsg_manycore_store_fence_ctrl dut16 (
        .clk_i(clk), .reset_i(reset_i), .proc_v_i(proc_v_i), .proc_is_store_i(proc_is_store_i),
        .proc_ready_o(rdy16), .net_v_o(v16), .net_ready_i(net_ready_i), .ret_v_i(ret_v_i),
        .ret_ready_i(ret_ready_i), .fence_req_i(fence_req_i), .fence_done_o(done16),
        .fence_busy_o(busy16), .out_count_o(cnt16), .error_o(err16));

    bsg_manycore_store_fence_ctrl #(
        .max_out_p(4)
`ifdef BSG_FENCE_TIMEOUT_EN
      , .timeout_p(8)
`endif
    ) dut4 (
        .clk_i(clk), .reset_i(reset_i), .proc_v_i(proc_v_i), .proc_is_store_i(proc_is_store_i),
        .proc_ready_o(rdy4), .net_v_o(v4), .net_ready_i(net_ready_i), .ret_v_i(ret_v_i),
        .ret_ready_i(ret_ready_i), .fence_req_i(fence_req_i), .fence_done_o(done4),
        .fence_busy_o(busy4), .out_count_o(cnt4), .error_o(err4));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        proc_v_i = 1'b0; proc_is_store_i = 1'b0; net_ready_i = 1'b1;
        ret_v_i = 1'b0; ret_ready_i = 1'b0; fence_req_i = 1'b0;
    endtask

    task automatic do_reset();
        idle_in();
        reset_i = 1'b0;
        @(negedge clk);
        reset_i = 1'b1;
        tick();
    endtask

    initial begin
        // reset state, with traffic presented during reset
        #1 reset_i = 1'b0;
        proc_v_i = 1'b1; proc_is_store_i = 1'b0; net_ready_i = 1'b1;
        @(negedge clk);
        chk("rst_net_v", v16, 0);
        chk("rst_proc_ready", rdy16, 0);
        chk("rst_count", cnt16, 0);
        chk("rst_error", err16, 0);
        chk("rst_busy", busy16, 0);
        chk("rst_done", done16, 0);
        tick();
        reset_i = 1'b1;
        idle_in();
        tick();

        // five stores then five returns on the 16-credit instance
        proc_v_i = 1'b1; proc_is_store_i = 1'b1;
        repeat (5) tick();
        proc_v_i = 1'b0;
        @(negedge clk);
        chk("cnt16_after5", cnt16, 5);
        chk("cnt4_saturated", cnt4, 4);
        tick();
        ret_v_i = 1'b1; ret_ready_i = 1'b1;
        repeat (5) tick();
        ret_v_i = 1'b0; ret_ready_i = 1'b0;
        @(negedge clk);
        chk("cnt16_drained", cnt16, 0);
        chk("err16_clean", err16, 0);
        tick();

        // credit limit of 4 with six back-to-back stores
        do_reset();
        proc_v_i = 1'b1; proc_is_store_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("thr_net_v", v4, (i < 4) ? 1 : 0);
            chk("thr_ready", rdy4, (i < 4) ? 1 : 0);
            tick();
        end
        chk("thr_count", cnt4, 4);
        proc_is_store_i = 1'b0;
        @(negedge clk);
        chk("nonstore_net_v", v4, 1);
        chk("nonstore_ready", rdy4, 1);
        tick();
        proc_is_store_i = 1'b1; ret_v_i = 1'b1; ret_ready_i = 1'b1;
        @(negedge clk);
        chk("full_store_blocked", v4, 0);
        tick();
        ret_v_i = 1'b0; ret_ready_i = 1'b0;
        @(negedge clk);
        chk("after_ret_count", cnt4, 3);
        chk("after_ret_accept", v4, 1);
        tick();
        proc_v_i = 1'b0;
        @(negedge clk);
        chk("refill_count", cnt4, 4);

        // simultaneous inc/dec, then underflow
        do_reset();
        proc_v_i = 1'b1; proc_is_store_i = 1'b1;
        repeat (3) tick();
        ret_v_i = 1'b1; ret_ready_i = 1'b1;
        tick();
        proc_v_i = 1'b0;
        @(negedge clk);
        chk("incdec_count", cnt4, 3);
        chk("incdec_error", err4, 0);
        repeat (3) tick();
        @(negedge clk);
        chk("zero_count", cnt4, 0);
        chk("zero_error", err4, 0);
        tick();
        ret_v_i = 1'b0; ret_ready_i = 1'b0;
        @(negedge clk);
        chk("uflow_count", cnt4, 0);
        chk("uflow_error", err4, 1);
        repeat (3) tick();
        @(negedge clk);
        chk("uflow_sticky", err4, 1);

        // fence with two outstanding, returns in cycles 3 and 7
        do_reset();
        proc_v_i = 1'b1; proc_is_store_i = 1'b1;
        repeat (2) tick();
        proc_v_i = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            fence_req_i = (k <= 9);
            ret_v_i = (k == 3 || k == 7); ret_ready_i = ret_v_i;
            proc_v_i = (k >= 1 && k <= 9); proc_is_store_i = k[0];
            @(negedge clk);
            chk("f2_done", done4, (k == 9) ? 1 : 0);
            chk("f2_busy", busy4, (k >= 1 && k <= 9) ? 1 : 0);
            if (k >= 1 && k <= 9) begin
                chk("f2_ready_blocked", rdy4, 0);
                chk("f2_net_v_blocked", v4, 0);
            end
            tick();
        end
        idle_in();
        @(negedge clk);
        chk("f2_count", cnt4, 0);
        chk("f2_error", err4, 0);

        // minimum latency fence at count 0
        do_reset();
        for (int k = 0; k <= 3; k++) begin
            fence_req_i = (k <= 2);
            @(negedge clk);
            chk("f0_done", done4, (k == 2) ? 1 : 0);
            tick();
        end

        // store accepted as the fence request rises must drain first
        do_reset();
        for (int k = 0; k <= 5; k++) begin
            fence_req_i = (k <= 4);
            proc_v_i = (k == 0); proc_is_store_i = 1'b1;
            ret_v_i = (k == 2); ret_ready_i = ret_v_i;
            @(negedge clk);
            chk("frise_done", done4, (k == 4) ? 1 : 0);
            if (k == 1) chk("frise_count", cnt4, 1);
            tick();
        end

        // reset in the middle of a fence
        do_reset();
        fence_req_i = 1'b1; proc_v_i = 1'b1; proc_is_store_i = 1'b1;
        tick();
        proc_v_i = 1'b0;
        @(negedge clk);
        chk("mid_busy", busy4, 1);
        chk("mid_count", cnt4, 1);
        tick();
        reset_i = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", busy4, 0);
        chk("mid_rst_done", done4, 0);
        chk("mid_rst_count", cnt4, 0);
        tick();
        reset_i = 1'b1; fence_req_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_done", done4, 0);
            chk("post_rst_busy", busy4, 0);
            tick();
        end

`ifdef BSG_FENCE_TIMEOUT_EN
        // watchdog: one store never acknowledged
        do_reset();
        proc_v_i = 1'b1; proc_is_store_i = 1'b1;
        tick();
        proc_v_i = 1'b0;
        for (int k = 0; k <= 11; k++) begin
            fence_req_i = (k <= 10);
            @(negedge clk);
            chk("to_done", done4, (k == 10) ? 1 : 0);
            tick();
        end
        @(negedge clk);
        chk("to_error", err4, 1);
        chk("to_count", cnt4, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
